div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions, placed in the EX stage beside the single-cycle ALU. It consumes the 5-bit `alusel` code produced by the ALU control unit and the two EX-stage operands. It computes the result with a radix-2 restoring iteration and holds the pipeline through a `stall` output until the result is ready. MUL-family and all other `alusel` codes are ignored and stay on the combinational ALU path.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width; only 32 is supported.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: the EX stage holds a valid instruction.
- `alusel` in 5: ALU select code, using the encodings in `include/defines.v`.
- `op_a` in 32: dividend (rs1).
- `op_b` in 32: divisor (rs2).
- `flush` in 1: EX-stage flush; aborts any operation in progress.
- `result` out 32: quotient or remainder, registered.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `busy` out 1: the unit is not in IDLE.
- `stall` out 1: freeze IF/ID/EX; combinational.

## Operation
- `is_div` = `alusel` ∈ {`ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`}.
- `start` = `valid_i & is_div & state==IDLE & !flush`.
- `stall` = `valid_i & is_div & !done & !flush`.
- States:
  - IDLE: on `start`, latch the op, operand signs and operand magnitudes. Go to DONE if this is a special case; otherwise go to CALC with `cnt`=0.
  - CALC: each cycle, shift {rem, quo} left by one; trial = rem − |divisor|, computed 33-bit. If trial ≥ 0, keep trial as rem and set quo[0]=1. After `cnt`=31, go to FIX.
  - FIX: apply signs. For DIV, negate the quotient if the operand signs differ. For REM, negate the remainder if the dividend is negative. Write the selected value to `result`, then go to DONE.
  - DONE: `done`=1, then go to IDLE unconditionally.
- Magnitudes: signed ops take the two's-complement absolute value. |0x80000000| = 0x80000000 is exact as unsigned. Unsigned ops use the raw operands.
- Special cases resolve in IDLE and write `result` directly:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Operands are latched at start. Changes on `op_a`, `op_b` or `alusel` while busy are ignored.
- The requester holds `valid_i`, `alusel` and the operands until `done`, then advances. Because `done` occurs in DONE, not IDLE, the same instruction cannot restart.
- `flush` in any state goes to IDLE next edge, with no `done`. `result` keeps its old value. `flush` and a would-be start in the same cycle produce no start.
- `rst` takes priority over everything. It forces IDLE, `result`=0, `done`=0 and `cnt`=0 at the next edge, including mid-operation.
- A non-div `alusel` with `valid_i` has no effect: `stall`=0 and the state is unchanged.

## Timing
- Reset values: `result`=0, `done`=0, `busy`=0, `stall`=0 when `valid_i`=0.
- Normal op, with start sampled at edge E0:
  - CALC covers edges E1..E32.
  - FIX covers E33; DONE occupies the cycle after E33.
  - `done` is high 34 cycles after the start cycle.
  - `stall` is high for 34 cycles: the start cycle plus 33 more.
- Special case: `done` is high in the cycle after E0. `stall` is high for exactly 1 cycle.
- `busy` is high from the cycle after E0 through the DONE cycle.
- Back-to-back divs: the next instruction reaches EX in the cycle after DONE, finds IDLE and starts at once. The gap is 0 idle cycles.
- `result` is stable from `done` until the next accepted start.

## Structure
- `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU` come from `include/defines.v`.
- Add the state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_FIX` and `DIV_DONE` (2 bits) to `include/defines.v`.
- Single module; no sub-module. The 33-bit subtractor and the 5-bit counter are local.

## Test plan
- DIVU 100 / 7 → `result`=14 with `done` 34 cycles after start. `stall` is high for 34 cycles; REMU 100 / 7 → 2.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIV 7 / −2 → 0xFFFFFFFD; REM 7 / −2 → 1.
- Divide by zero, op_a=0x12345678, op_b=0:
  - DIV → 0xFFFFFFFF with `done` 1 cycle after start.
  - REMU → 0x12345678.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000 and REM → 0, each in 1 cycle. DIVU 0x80000000 / 0xFFFFFFFF → 0 after the full 34 cycles.
- `flush` at cycle 10 of a DIV → IDLE with no `done` pulse and `stall` low. A following DIVU 9 / 3 → 3 on schedule. Repeat with `rst` instead: `result` becomes 0.
- Two consecutive DIVs (20/4, then 15/5) → 5, then 3, with no idle gap. `valid_i` with `alusel`=`ALU_ADD` → `stall`=0 and `busy`=0 throughout.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg
// Shared definitions for the EX-stage integer divider.
//   - ALU select codes produced by the ALU control unit. Only the four
//     divide/remainder codes matter to the divider. The rest are listed so
//     that every consumer of alusel agrees on one encoding.
//   - div_state_e: the divider FSM states (2-bit encoding).
//   - is_div_op(): decodes an alusel value into "this is a divider op".
package div_unit_pkg;

  localparam int unsigned ALU_SEL_W = 5;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_SEL_W-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL    = 5'd10;
  localparam logic [ALU_SEL_W-1:0] ALU_MULH   = 5'd11;
  localparam logic [ALU_SEL_W-1:0] ALU_MULHSU = 5'd12;
  localparam logic [ALU_SEL_W-1:0] ALU_MULHU  = 5'd13;
  localparam logic [ALU_SEL_W-1:0] ALU_DIV    = 5'd14;
  localparam logic [ALU_SEL_W-1:0] ALU_DIVU   = 5'd15;
  localparam logic [ALU_SEL_W-1:0] ALU_REM    = 5'd16;
  localparam logic [ALU_SEL_W-1:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // True for the four codes the divider owns. Every other code, MUL included,
  // stays on the single-cycle ALU path.
  function automatic logic is_div_op(input logic [ALU_SEL_W-1:0] sel);
    return sel inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. It sits
// in EX beside the ALU and holds the pipeline until its result is ready.
// A normal operation takes 32 CALC cycles plus one FIX cycle. done then pulses
// 34 cycles after the start cycle. Divide-by-zero and signed overflow resolve
// at once, and done pulses in the cycle after start.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   valid_i  in   EX stage holds a valid instruction
//   alusel   in   5-bit ALU select code (see div_unit_pkg)
//   op_a     in   dividend (rs1)
//   op_b     in   divisor  (rs2)
//   flush    in   EX-stage flush, abandons any operation in progress
//   result   out  registered quotient / remainder
//   done     out  one-cycle pulse, result valid in that cycle
//   busy     out  FSM is not idle
//   stall    out  combinational freeze request for IF/ID/EX
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [ALU_SEL_W-1:0] alusel,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic                 flush,
  output logic [XLEN-1:0]      result,
  output logic                 done,
  output logic                 busy,
  output logic                 stall
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  divisor_q;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  result_q;
  logic             done_q;

  logic            is_div;
  logic            is_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic            start;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  // Decode the incoming request. Magnitudes use the two's-complement absolute
  // value only for signed ops. |INT_MIN| wraps back to INT_MIN, which is the
  // correct magnitude when read as unsigned.
  always_comb begin
    is_div      = is_div_op(alusel);
    is_signed   = (alusel == ALU_DIV) || (alusel == ALU_REM);
    is_rem      = (alusel == ALU_REM) || (alusel == ALU_REMU);
    a_neg       = is_signed & op_a[XLEN-1];
    b_neg       = is_signed & op_b[XLEN-1];
    a_mag       = a_neg ? ({XLEN{1'b0}} - op_a) : op_a;
    b_mag       = b_neg ? ({XLEN{1'b0}} - op_b) : op_b;
    div_by_zero = (op_b == {XLEN{1'b0}});
    overflow    = is_signed && (op_a == INT_MIN) && (op_b == {XLEN{1'b1}});
    // Overflow quotient is the dividend itself (INT_MIN). Overflow remainder is 0.
    if (div_by_zero) begin
      special_res = is_rem ? op_a : {XLEN{1'b1}};
    end else begin
      special_res = is_rem ? {XLEN{1'b0}} : op_a;
    end
    start = valid_i & is_div & (state_q == DIV_IDLE) & ~flush;
  end

  // One restoring step. The shifted partial remainder is XLEN+1 bits wide.
  // When its top bit is set it already exceeds any divisor. Otherwise the
  // subtractor's top bit is the borrow that says the divisor did not fit.
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, divisor_q};
    fits      = shifted[XLEN] | ~trial[XLEN];
    rem_d     = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], fits};
    quo_fixed = neg_quo_q ? ({XLEN{1'b0}} - quo_q) : quo_q;
    rem_fixed = neg_rem_q ? ({XLEN{1'b0}} - rem_q) : rem_q;
  end

  // Divider FSM with registered result/done. Reset beats flush, and flush
  // beats everything else. A flushed operation returns to IDLE without a
  // done pulse and leaves the previous result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else if (flush) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            is_rem_q  <= is_rem;
            neg_quo_q <= ~is_rem & (a_neg ^ b_neg);
            neg_rem_q <= is_rem & a_neg;
            rem_q     <= '0;
            quo_q     <= a_mag;
            divisor_q <= b_mag;
            cnt_q     <= '0;
            if (div_by_zero || overflow) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= DIV_DONE;
            end else begin
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          result_q <= is_rem_q ? rem_fixed : quo_fixed;
          done_q   <= 1'b1;
          state_q  <= DIV_DONE;
        end
        DIV_DONE: begin
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  // The stall drops in the done cycle so the requester can advance. The next
  // instruction then finds the FSM idle one cycle later and starts with no gap.
  always_comb begin
    result = result_q;
    done   = done_q;
    busy   = (state_q != DIV_IDLE);
    stall  = valid_i & is_div & ~done_q & ~flush;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit
// Self-checking bench for div_unit. It runs directed vectors from a table,
// randomized operations against an arithmetic reference model, and
// hand-written flush / reset / non-div sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [4:0]  aluSel;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastResult = 32'd0;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
    string       name;
  } vec_t;

  div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid),
    .alusel  (aluSel),
    .op_a    (opA),
    .op_b    (opB),
    .flush   (flush),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .stall   (stall)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain arithmetic. It uses 64-bit signed division, which
  // truncates toward zero. The overflow case falls out of the 32-bit wrap.
  function automatic logic [31:0] refResult(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic signedOp;
    logic remOp;
    signedOp = (sel == ALU_DIV) || (sel == ALU_REM);
    remOp    = (sel == ALU_REM) || (sel == ALU_REMU);
    if (b == 32'd0) return remOp ? a : 32'hFFFF_FFFF;
    if (signedOp) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return remOp ? r[31:0] : q[31:0];
  endfunction

  function automatic int refLatency(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic signedOp;
    signedOp = (sel == ALU_DIV) || (sel == ALU_REM);
    if (b == 32'd0) return 1;
    if (signedOp && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one div request at the next falling edge and holds it until done.
  // It then checks the cycles to done, the stall length, busy and the result.
  // With scramble set, the operands are overwritten mid-operation. They must
  // be ignored because the unit latched them at start.
  task automatic applyStimulus(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input int expLat, input string name,
                               input bit scramble);
    int cyc;
    int stallCycles;
    bit seen;
    @(negedge clk);
    valid  = 1'b1;
    aluSel = sel;
    opA    = a;
    opB    = b;
    cyc = 0;
    stallCycles = 0;
    seen = 1'b0;
    while (cyc < 60 && !seen) begin
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (stall) stallCycles++;
        @(negedge clk);
        cyc++;
        if (scramble && cyc == 5) begin
          opA = $urandom;
          opB = $urandom;
        end
      end
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({name, "_latency"}, 32'(cyc), 32'(expLat));
    checkOutput({name, "_stall_cycles"}, 32'(stallCycles), 32'(expLat));
    checkOutput({name, "_stall_in_done"}, 32'(stall), 32'd0);
    checkOutput({name, "_busy_in_done"}, 32'(busy), 32'd1);
    checkOutput({name, "_result"}, result, expRes);
    lastResult = expRes;
  endtask

  task automatic releaseBus();
    @(negedge clk);
    valid  = 1'b0;
    aluSel = ALU_ADD;
  endtask

  // Starts a signed DIV, then at cycle 10 applies flush or reset for one cycle.
  task automatic abortSequence(input bit useReset, input logic [31:0] expResultAfter);
    @(negedge clk);
    valid  = 1'b1;
    aluSel = ALU_DIV;
    opA    = 32'hFFFF_FF9C;
    opB    = 32'd7;
    repeat (10) begin
      @(negedge clk);
      #1;
      checkOutput("abort_no_early_done", 32'(done), 32'd0);
    end
    if (useReset) rst = 1'b1;
    else flush = 1'b1;
    #1;
    if (!useReset) checkOutput("flush_stall_low", 32'(stall), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    flush  = 1'b0;
    valid  = 1'b0;
    #1;
    checkOutput(useReset ? "reset_busy" : "flush_busy", 32'(busy), 32'd0);
    checkOutput(useReset ? "reset_result" : "flush_result", result, expResultAfter);
    repeat (40) begin
      @(negedge clk);
      #1;
      checkOutput(useReset ? "reset_no_done" : "flush_no_done", 32'(done), 32'd0);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [4:0]  rSel;
    logic [31:0] rA;
    logic [31:0] rB;
    logic [4:0]  divCodes [4];

    vecs[0]  = '{ALU_DIVU, 32'd100,        32'd7,          32'd14,         34, "divu_100_7"};
    vecs[1]  = '{ALU_REMU, 32'd100,        32'd7,          32'd2,          34, "remu_100_7"};
    vecs[2]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, "div_m7_2"};
    vecs[3]  = '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, "rem_m7_2"};
    vecs[4]  = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, "div_7_m2"};
    vecs[5]  = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, "rem_7_m2"};
    vecs[6]  = '{ALU_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1,  "div_by_zero"};
    vecs[7]  = '{ALU_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1,  "remu_by_zero"};
    vecs[8]  = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_overflow"};
    vecs[9]  = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_overflow"};
    vecs[10] = '{ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, "divu_big"};
    vecs[11] = '{ALU_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34, "div_intmin_2"};

    divCodes[0] = ALU_DIV;
    divCodes[1] = ALU_DIVU;
    divCodes[2] = ALU_REM;
    divCodes[3] = ALU_REMU;

    rst    = 1'b1;
    valid  = 1'b0;
    aluSel = ALU_ADD;
    opA    = 32'd0;
    opB    = 32'd0;
    flush  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);

    // Directed table, issued back-to-back with valid held high.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expLat, vecs[i].name, 1'b0);
    end
    releaseBus();

    // Operands changing mid-operation must not disturb the latched values.
    applyStimulus(ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_scrambled", 1'b1);
    releaseBus();

    // Flush in the middle of a DIV, then a fresh DIVU on schedule.
    abortSequence(1'b0, lastResult);
    applyStimulus(ALU_DIVU, 32'd9, 32'd3, 32'd3, 34, "divu_after_flush", 1'b0);
    releaseBus();

    // The same abort driven by reset clears the result.
    abortSequence(1'b1, 32'd0);
    applyStimulus(ALU_DIVU, 32'd9, 32'd3, 32'd3, 34, "divu_after_reset", 1'b0);

    // Two consecutive DIVs with no idle gap.
    applyStimulus(ALU_DIV, 32'd20, 32'd4, 32'd5, 34, "b2b_first", 1'b0);
    applyStimulus(ALU_DIV, 32'd15, 32'd5, 32'd3, 34, "b2b_second", 1'b0);
    releaseBus();

    // A non-div op with valid high must neither stall nor wake the unit.
    @(negedge clk);
    valid  = 1'b1;
    aluSel = ALU_ADD;
    opA    = 32'd5;
    opB    = 32'd0;
    repeat (6) begin
      #1;
      checkOutput("add_stall", 32'(stall), 32'd0);
      checkOutput("add_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    valid = 1'b0;

    // Randomized operations against the reference model, back-to-back.
    for (int n = 0; n < 40; n++) begin
      rSel = divCodes[$urandom_range(0, 3)];
      case ($urandom_range(0, 7))
        0: begin rA = $urandom; rB = 32'd0; end
        1: begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
        2: begin rA = $urandom_range(0, 1000); rB = $urandom_range(1, 40); end
        3: begin rA = -$urandom_range(0, 1000); rB = $urandom_range(1, 40); end
        default: begin rA = $urandom; rB = $urandom >> $urandom_range(0, 31); end
      endcase
      applyStimulus(rSel, rA, rB, refResult(rSel, rA, rB), refLatency(rSel, rA, rB), $sformatf("rand%0d", n), 1'b0);
    end
    releaseBus();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
